reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Eight-entry unified reservation station for the dual-issue out-of-order core; the storage side of the allocate/issue handshake.
- Receives up to two dispatched instructions per cycle into entry indices chosen by the allocator.
- Captures operands from two CDB broadcasts, and exports per-entry free and ready vectors back to the allocator.
- Reads out up to two allocator-selected ready entries per cycle to the execution units and frees them.

Parameters:
N_ENTRIES, 8, number of entries; index width is log2(N_ENTRIES)=3
TAG_W, 4, producer (ROB) tag width
DATA_W, 32, operand width
OP_W, 5, opcode/control width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous squash of all entries
disp_valid0, disp_valid1  input  1  dispatch slot k valid
disp_idx0, disp_idx1  input  3  target entry for slot k (allocator rs_entry k)
disp_op0, disp_op1  input  OP_W  opcode
disp_dst0, disp_dst1  input  TAG_W  destination tag
disp_s1_rdy0/1, disp_s2_rdy0/1  input  1  source j value already valid
disp_s1_tag0/1, disp_s2_tag0/1  input  TAG_W  source j producer tag
disp_s1_val0/1, disp_s2_val0/1  input  DATA_W  source j value
cdb_valid0, cdb_valid1  input  1  CDB k broadcast valid
cdb_tag0, cdb_tag1  input  TAG_W  CDB k tag
cdb_data0, cdb_data1  input  DATA_W  CDB k result
iss_valid0, iss_valid1  input  1  issue slot k request
iss_idx0, iss_idx1  input  3  entry to issue (allocator rs_issue k)
free_rs  output  [0:N_ENTRIES-1]  bit j=1 when entry j empty
rdy  output  [0:N_ENTRIES-1]  bit j=1 when entry j busy and both sources ready
ex_valid0, ex_valid1  output  1  issued instruction k valid (registered)
ex_op0/1, ex_dst0/1  output  OP_W/TAG_W  issued opcode, dest tag
ex_a0/1, ex_b0/1  output  DATA_W  issued source 1 and source 2 values
err  output  1  one-cycle protocol-error pulse

Behaviour:
- Entry state: busy, op, dst, s1_rdy/tag/val, s2_rdy/tag/val.
- free_rs[j] = ~busy[j]; rdy[j] = busy[j] & s1_rdy[j] & s2_rdy[j]. Both are combinational from registered state only; no input-to-output combinational path.
- Reset (rst=1 at an edge): all busy=0, so free_rs=all ones and rdy=0. ex_valid0/1=0, all ex_* data=0, err=0. rst has priority over every other input.
- Flush: at that edge, all busy=0 and ex_valid0/1=0. Same-cycle dispatch and issue are discarded. No err.
- Dispatch, per slot k with disp_valid k=1 and entry disp_idx k free:
  - At the edge, write the entry and set busy=1.
  - A source with disp rdy=0 whose tag matches a same-cycle valid CDB is stored ready with the CDB data (bypass). CDB0 wins if both CDBs match.
- Wakeup: for each busy entry with a non-ready source whose tag equals cdb_tag k with cdb_valid k, set that source ready and latch the data at the edge. Both CDBs are checked; CDB0 has priority on a tag collision. Ready sources are never overwritten.
- Issue, per slot k with iss_valid k=1 and rdy[iss_idx k]=1 (pre-edge state):
  - At the edge, ex_*k is loaded from the entry, ex_valid k=1, and busy is cleared.
  - Latency: request in cycle N, ex_valid in N+1, free_rs bit set in N+1.
  - ex_valid k=0 in every cycle with no legal issue on slot k; ex data holds its last value.
- A freed entry is allocatable in the cycle it frees. Issue and dispatch to the same entry in one cycle cannot be legal: dispatch requires free, issue requires busy.
- Protocol errors: the offending operation is dropped and err pulses for one cycle at the next edge.
  - Dispatch to a busy entry.
  - disp_idx0==disp_idx1 with both dispatch slots valid: slot0 is accepted, slot1 is dropped.
  - Issue of an entry with rdy=0.
  - iss_idx0==iss_idx1 with both issue slots valid: slot0 is accepted, slot1 is dropped.
- With all 8 entries busy, free_rs=0; dispatch attempts produce err only.

Test Plan:
- Reset then idle -> free_rs=8'hFF, rdy=0, ex_valid0/1=0, err=0.
- Dispatch entries 0 and 1 with both sources ready (0x5/0x7, 0x10/0x20) -> next cycle free_rs=8'h3F and rdy bits 0,1 set. Issue 0 and 1 -> following cycle ex_valid0/1=1, ex_a0=0x5, ex_b1=0x20, free_rs=8'hFF.
- Dispatch entry 3 with s1 waiting on tag 6. Broadcast cdb_tag1=6, cdb_data1=0xABCD two cycles later -> rdy[3] rises the cycle after the broadcast; an issue then gives ex_a=0xABCD.
- Dispatch with s2 tag 9 not ready while cdb_valid0 carries tag 9, data 0x42 in the same cycle -> entry is ready the next cycle with s2=0x42.
- Fill all 8 entries, then dispatch to entry 2 -> entry contents unchanged, err pulses once, free_rs=0.
- 4 busy entries, flush asserted together with a dispatch and an issue -> next cycle free_rs=8'hFF, ex_valid=0, err=0.

Source files
------------

// File: rtl/reservation_station.sv
// Eight-entry unified reservation station: dual dispatch, dual CDB wakeup with
// same-cycle bypass, dual issue with registered execute outputs and error pulse.
module reservation_station #(
    parameter int unsigned N_ENTRIES = 8,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OP_W      = 5,
    localparam int unsigned IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   disp_valid0,
    input  logic                   disp_valid1,
    input  logic [IDX_W-1:0]       disp_idx0,
    input  logic [IDX_W-1:0]       disp_idx1,
    input  logic [OP_W-1:0]        disp_op0,
    input  logic [OP_W-1:0]        disp_op1,
    input  logic [TAG_W-1:0]       disp_dst0,
    input  logic [TAG_W-1:0]       disp_dst1,
    input  logic                   disp_s1_rdy0,
    input  logic                   disp_s1_rdy1,
    input  logic                   disp_s2_rdy0,
    input  logic                   disp_s2_rdy1,
    input  logic [TAG_W-1:0]       disp_s1_tag0,
    input  logic [TAG_W-1:0]       disp_s1_tag1,
    input  logic [TAG_W-1:0]       disp_s2_tag0,
    input  logic [TAG_W-1:0]       disp_s2_tag1,
    input  logic [DATA_W-1:0]      disp_s1_val0,
    input  logic [DATA_W-1:0]      disp_s1_val1,
    input  logic [DATA_W-1:0]      disp_s2_val0,
    input  logic [DATA_W-1:0]      disp_s2_val1,
    input  logic                   cdb_valid0,
    input  logic                   cdb_valid1,
    input  logic [TAG_W-1:0]       cdb_tag0,
    input  logic [TAG_W-1:0]       cdb_tag1,
    input  logic [DATA_W-1:0]      cdb_data0,
    input  logic [DATA_W-1:0]      cdb_data1,
    input  logic                   iss_valid0,
    input  logic                   iss_valid1,
    input  logic [IDX_W-1:0]       iss_idx0,
    input  logic [IDX_W-1:0]       iss_idx1,
    output logic [0:N_ENTRIES-1]   free_rs,
    output logic [0:N_ENTRIES-1]   rdy,
    output logic                   ex_valid0,
    output logic                   ex_valid1,
    output logic [OP_W-1:0]        ex_op0,
    output logic [OP_W-1:0]        ex_op1,
    output logic [TAG_W-1:0]       ex_dst0,
    output logic [TAG_W-1:0]       ex_dst1,
    output logic [DATA_W-1:0]      ex_a0,
    output logic [DATA_W-1:0]      ex_a1,
    output logic [DATA_W-1:0]      ex_b0,
    output logic [DATA_W-1:0]      ex_b1,
    output logic                   err
);

    logic [N_ENTRIES-1:0] busy_q, busy_d;
    logic [N_ENTRIES-1:0] s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [OP_W-1:0]      op_q     [N_ENTRIES];
    logic [OP_W-1:0]      op_d     [N_ENTRIES];
    logic [TAG_W-1:0]     dst_q    [N_ENTRIES];
    logic [TAG_W-1:0]     dst_d    [N_ENTRIES];
    logic [TAG_W-1:0]     s1_tag_q [N_ENTRIES];
    logic [TAG_W-1:0]     s1_tag_d [N_ENTRIES];
    logic [TAG_W-1:0]     s2_tag_q [N_ENTRIES];
    logic [TAG_W-1:0]     s2_tag_d [N_ENTRIES];
    logic [DATA_W-1:0]    s1_val_q [N_ENTRIES];
    logic [DATA_W-1:0]    s1_val_d [N_ENTRIES];
    logic [DATA_W-1:0]    s2_val_q [N_ENTRIES];
    logic [DATA_W-1:0]    s2_val_d [N_ENTRIES];

    logic                 ex_valid0_q, ex_valid0_d, ex_valid1_q, ex_valid1_d;
    logic [OP_W-1:0]      ex_op0_q, ex_op0_d, ex_op1_q, ex_op1_d;
    logic [TAG_W-1:0]     ex_dst0_q, ex_dst0_d, ex_dst1_q, ex_dst1_d;
    logic [DATA_W-1:0]    ex_a0_q, ex_a0_d, ex_a1_q, ex_a1_d;
    logic [DATA_W-1:0]    ex_b0_q, ex_b0_d, ex_b1_q, ex_b1_d;
    logic                 err_q, err_d;

    logic iss_ok0, iss_ok1, disp_ok0, disp_ok1;

    // Returns {ready, value}; a ready source passes through untouched, CDB0 wins ties.
    function automatic logic [DATA_W:0] snoop(input logic             rdy_i,
                                              input logic [TAG_W-1:0]  tag_i,
                                              input logic [DATA_W-1:0] val_i);
        logic [DATA_W:0] res;
        res = {rdy_i, val_i};
        if (!rdy_i) begin
            if (cdb_valid0 && (cdb_tag0 == tag_i)) begin
                res = {1'b1, cdb_data0};
            end else if (cdb_valid1 && (cdb_tag1 == tag_i)) begin
                res = {1'b1, cdb_data1};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int j = 0; j < N_ENTRIES; j++) begin
            free_rs[j] = ~busy_q[j];
            rdy[j]     = busy_q[j] & s1_rdy_q[j] & s2_rdy_q[j];
        end
    end

    always_comb begin
        busy_d      = busy_q;
        s1_rdy_d    = s1_rdy_q;
        s2_rdy_d    = s2_rdy_q;
        op_d        = op_q;
        dst_d       = dst_q;
        s1_tag_d    = s1_tag_q;
        s2_tag_d    = s2_tag_q;
        s1_val_d    = s1_val_q;
        s2_val_d    = s2_val_q;
        ex_valid0_d = 1'b0;
        ex_valid1_d = 1'b0;
        ex_op0_d    = ex_op0_q;
        ex_op1_d    = ex_op1_q;
        ex_dst0_d   = ex_dst0_q;
        ex_dst1_d   = ex_dst1_q;
        ex_a0_d     = ex_a0_q;
        ex_a1_d     = ex_a1_q;
        ex_b0_d     = ex_b0_q;
        ex_b1_d     = ex_b1_q;
        err_d       = 1'b0;

        iss_ok0  = iss_valid0 & rdy[iss_idx0];
        iss_ok1  = iss_valid1 & rdy[iss_idx1] & ~(iss_valid0 & (iss_idx0 == iss_idx1));
        disp_ok0 = disp_valid0 & ~busy_q[disp_idx0];
        disp_ok1 = disp_valid1 & ~busy_q[disp_idx1]
                 & ~(disp_valid0 & (disp_idx0 == disp_idx1));

        if (flush) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (busy_q[j]) begin
                    {s1_rdy_d[j], s1_val_d[j]} = snoop(s1_rdy_q[j], s1_tag_q[j], s1_val_q[j]);
                    {s2_rdy_d[j], s2_val_d[j]} = snoop(s2_rdy_q[j], s2_tag_q[j], s2_val_q[j]);
                end
            end

            // Issue and dispatch targets are disjoint: issue needs busy, dispatch needs free.
            if (iss_ok0) begin
                ex_valid0_d      = 1'b1;
                ex_op0_d         = op_q[iss_idx0];
                ex_dst0_d        = dst_q[iss_idx0];
                ex_a0_d          = s1_val_q[iss_idx0];
                ex_b0_d          = s2_val_q[iss_idx0];
                busy_d[iss_idx0] = 1'b0;
            end
            if (iss_ok1) begin
                ex_valid1_d      = 1'b1;
                ex_op1_d         = op_q[iss_idx1];
                ex_dst1_d        = dst_q[iss_idx1];
                ex_a1_d          = s1_val_q[iss_idx1];
                ex_b1_d          = s2_val_q[iss_idx1];
                busy_d[iss_idx1] = 1'b0;
            end

            if (disp_ok0) begin
                busy_d[disp_idx0]   = 1'b1;
                op_d[disp_idx0]     = disp_op0;
                dst_d[disp_idx0]    = disp_dst0;
                s1_tag_d[disp_idx0] = disp_s1_tag0;
                s2_tag_d[disp_idx0] = disp_s2_tag0;
                {s1_rdy_d[disp_idx0], s1_val_d[disp_idx0]} =
                    snoop(disp_s1_rdy0, disp_s1_tag0, disp_s1_val0);
                {s2_rdy_d[disp_idx0], s2_val_d[disp_idx0]} =
                    snoop(disp_s2_rdy0, disp_s2_tag0, disp_s2_val0);
            end
            if (disp_ok1) begin
                busy_d[disp_idx1]   = 1'b1;
                op_d[disp_idx1]     = disp_op1;
                dst_d[disp_idx1]    = disp_dst1;
                s1_tag_d[disp_idx1] = disp_s1_tag1;
                s2_tag_d[disp_idx1] = disp_s2_tag1;
                {s1_rdy_d[disp_idx1], s1_val_d[disp_idx1]} =
                    snoop(disp_s1_rdy1, disp_s1_tag1, disp_s1_val1);
                {s2_rdy_d[disp_idx1], s2_val_d[disp_idx1]} =
                    snoop(disp_s2_rdy1, disp_s2_tag1, disp_s2_val1);
            end

            err_d = (iss_valid0 & ~iss_ok0) | (iss_valid1 & ~iss_ok1)
                  | (disp_valid0 & ~disp_ok0) | (disp_valid1 & ~disp_ok1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            for (int j = 0; j < N_ENTRIES; j++) begin
                op_q[j]     <= '0;
                dst_q[j]    <= '0;
                s1_tag_q[j] <= '0;
                s2_tag_q[j] <= '0;
                s1_val_q[j] <= '0;
                s2_val_q[j] <= '0;
            end
            ex_valid0_q <= 1'b0;
            ex_valid1_q <= 1'b0;
            ex_op0_q    <= '0;
            ex_op1_q    <= '0;
            ex_dst0_q   <= '0;
            ex_dst1_q   <= '0;
            ex_a0_q     <= '0;
            ex_a1_q     <= '0;
            ex_b0_q     <= '0;
            ex_b1_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            s1_tag_q    <= s1_tag_d;
            s2_tag_q    <= s2_tag_d;
            s1_val_q    <= s1_val_d;
            s2_val_q    <= s2_val_d;
            ex_valid0_q <= ex_valid0_d;
            ex_valid1_q <= ex_valid1_d;
            ex_op0_q    <= ex_op0_d;
            ex_op1_q    <= ex_op1_d;
            ex_dst0_q   <= ex_dst0_d;
            ex_dst1_q   <= ex_dst1_d;
            ex_a0_q     <= ex_a0_d;
            ex_a1_q     <= ex_a1_d;
            ex_b0_q     <= ex_b0_d;
            ex_b1_q     <= ex_b1_d;
            err_q       <= err_d;
        end
    end

    assign ex_valid0 = ex_valid0_q;
    assign ex_valid1 = ex_valid1_q;
    assign ex_op0    = ex_op0_q;
    assign ex_op1    = ex_op1_q;
    assign ex_dst0   = ex_dst0_q;
    assign ex_dst1   = ex_dst1_q;
    assign ex_a0     = ex_a0_q;
    assign ex_a1     = ex_a1_q;
    assign ex_b0     = ex_b0_q;
    assign ex_b1     = ex_b1_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: an entry-level model of the station
// is checked against the DUT every cycle, plus hand-computed literal checks.
module tb_reservation_station;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        dv[2], dr1[2], dr2[2], cv[2], iv[2];
    logic [2:0]  di[2], ii[2];
    logic [4:0]  dop[2];
    logic [3:0]  ddst[2], dt1[2], dt2[2], ct[2];
    logic [31:0] dva1[2], dva2[2], cd[2];

    logic [0:7]  free_rs, rdy;
    logic        ex_valid0, ex_valid1, err;
    logic [4:0]  ex_op0, ex_op1;
    logic [3:0]  ex_dst0, ex_dst1;
    logic [31:0] ex_a0, ex_a1, ex_b0, ex_b1;

    reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid0(dv[0]), .disp_valid1(dv[1]),
        .disp_idx0(di[0]), .disp_idx1(di[1]),
        .disp_op0(dop[0]), .disp_op1(dop[1]),
        .disp_dst0(ddst[0]), .disp_dst1(ddst[1]),
        .disp_s1_rdy0(dr1[0]), .disp_s1_rdy1(dr1[1]),
        .disp_s2_rdy0(dr2[0]), .disp_s2_rdy1(dr2[1]),
        .disp_s1_tag0(dt1[0]), .disp_s1_tag1(dt1[1]),
        .disp_s2_tag0(dt2[0]), .disp_s2_tag1(dt2[1]),
        .disp_s1_val0(dva1[0]), .disp_s1_val1(dva1[1]),
        .disp_s2_val0(dva2[0]), .disp_s2_val1(dva2[1]),
        .cdb_valid0(cv[0]), .cdb_valid1(cv[1]),
        .cdb_tag0(ct[0]), .cdb_tag1(ct[1]),
        .cdb_data0(cd[0]), .cdb_data1(cd[1]),
        .iss_valid0(iv[0]), .iss_valid1(iv[1]),
        .iss_idx0(ii[0]), .iss_idx1(ii[1]),
        .free_rs(free_rs), .rdy(rdy),
        .ex_valid0(ex_valid0), .ex_valid1(ex_valid1),
        .ex_op0(ex_op0), .ex_op1(ex_op1),
        .ex_dst0(ex_dst0), .ex_dst1(ex_dst1),
        .ex_a0(ex_a0), .ex_a1(ex_a1),
        .ex_b0(ex_b0), .ex_b1(ex_b1),
        .err(err)
    );

    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [3:0]  dst;
        bit          r1;
        logic [3:0]  t1;
        logic [31:0] v1;
        bit          r2;
        logic [3:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t        m[8], n[8];
    bit          mv[2], nv[2], merr, nerr;
    logic [4:0]  mop[2], nop[2];
    logic [3:0]  mdst[2], ndst[2];
    logic [31:0] ma[2], na[2], mb[2], nb[2];

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    logic [0:7] ef, er;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A waiting source captures a matching CDB value, CDB0 first.
    function automatic void snoop(input bit r, input logic [3:0] t, input logic [31:0] v,
                                  output bit ro, output logic [31:0] vo);
        ro = r;
        vo = v;
        if (!r) begin
            if (cv[0] && ct[0] == t) begin
                ro = 1'b1;
                vo = cd[0];
            end else if (cv[1] && ct[1] == t) begin
                ro = 1'b1;
                vo = cd[1];
            end
        end
    endfunction

    task automatic clear_in();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dv[k] = 0; di[k] = '0; dop[k] = '0; ddst[k] = '0;
            dr1[k] = 0; dr2[k] = 0; dt1[k] = '0; dt2[k] = '0; dva1[k] = '0; dva2[k] = '0;
            cv[k] = 0; ct[k] = '0; cd[k] = '0; iv[k] = 0; ii[k] = '0;
        end
    endtask

    task automatic model_next();
        n = m;
        nerr = 1'b0;
        nv = '{0, 0};
        nop = mop; ndst = mdst; na = ma; nb = mb;
        if (rst) begin
            for (int j = 0; j < 8; j++) n[j].busy = 0;
            nop = '{0, 0}; ndst = '{0, 0}; na = '{0, 0}; nb = '{0, 0};
        end else if (flush) begin
            for (int j = 0; j < 8; j++) n[j].busy = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (iv[k]) begin
                    if (k == 1 && iv[0] && ii[0] == ii[1]) nerr = 1'b1;
                    else if (!(m[ii[k]].busy && m[ii[k]].r1 && m[ii[k]].r2)) nerr = 1'b1;
                    else begin
                        nv[k] = 1'b1;
                        nop[k] = m[ii[k]].op;
                        ndst[k] = m[ii[k]].dst;
                        na[k] = m[ii[k]].v1;
                        nb[k] = m[ii[k]].v2;
                        n[ii[k]].busy = 0;
                    end
                end
            end
            for (int j = 0; j < 8; j++) begin
                if (m[j].busy) begin
                    snoop(m[j].r1, m[j].t1, m[j].v1, n[j].r1, n[j].v1);
                    snoop(m[j].r2, m[j].t2, m[j].v2, n[j].r2, n[j].v2);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (dv[k]) begin
                    if (k == 1 && dv[0] && di[0] == di[1]) nerr = 1'b1;
                    else if (m[di[k]].busy) nerr = 1'b1;
                    else begin
                        n[di[k]].busy = 1;
                        n[di[k]].op = dop[k];
                        n[di[k]].dst = ddst[k];
                        n[di[k]].t1 = dt1[k];
                        n[di[k]].t2 = dt2[k];
                        snoop(dr1[k], dt1[k], dva1[k], n[di[k]].r1, n[di[k]].v1);
                        snoop(dr2[k], dt2[k], dva2[k], n[di[k]].r2, n[di[k]].v2);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        m = n; mv = nv; mop = nop; mdst = ndst; ma = na; mb = nb; merr = nerr;
        #1;
        clear_in();
    endtask

    task automatic disp(input int k, input logic [2:0] idx, input logic [4:0] op,
                        input logic [3:0] dst, input bit r1, input logic [3:0] t1,
                        input logic [31:0] v1, input bit r2, input logic [3:0] t2,
                        input logic [31:0] v2);
        dv[k] = 1; di[k] = idx; dop[k] = op; ddst[k] = dst;
        dr1[k] = r1; dt1[k] = t1; dva1[k] = v1; dr2[k] = r2; dt2[k] = t2; dva2[k] = v2;
    endtask

    task automatic iss(input int k, input logic [2:0] idx);
        iv[k] = 1; ii[k] = idx;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 8; j++) begin
                ef[j] = !m[j].busy;
                er[j] = m[j].busy && m[j].r1 && m[j].r2;
            end
            chk("free_rs", free_rs, ef);
            chk("rdy", rdy, er);
            chk("ex_valid0", ex_valid0, mv[0]);
            chk("ex_valid1", ex_valid1, mv[1]);
            chk("ex_op0", ex_op0, mop[0]);
            chk("ex_op1", ex_op1, mop[1]);
            chk("ex_dst0", ex_dst0, mdst[0]);
            chk("ex_dst1", ex_dst1, mdst[1]);
            chk("ex_a0", ex_a0, ma[0]);
            chk("ex_a1", ex_a1, ma[1]);
            chk("ex_b0", ex_b0, mb[0]);
            chk("ex_b1", ex_b1, mb[1]);
            chk("err", err, merr);
        end
    end

    initial begin
        clear_in();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;

        cycle();
        chk("lit_reset_free", free_rs, 8'hFF);
        chk("lit_reset_rdy", rdy, 8'h00);
        chk("lit_reset_exv", {ex_valid0, ex_valid1}, 2'b00);
        chk("lit_reset_err", err, 1'b0);

        disp(0, 3'd0, 5'h01, 4'h1, 1, 4'h0, 32'h5, 1, 4'h0, 32'h7);
        disp(1, 3'd1, 5'h02, 4'h2, 1, 4'h0, 32'h10, 1, 4'h0, 32'h20);
        cycle();
        chk("lit_disp_free", free_rs, 8'h3F);
        chk("lit_disp_rdy", rdy, 8'hC0);
        iss(0, 3'd0);
        iss(1, 3'd1);
        cycle();
        chk("lit_iss_exv", {ex_valid0, ex_valid1}, 2'b11);
        chk("lit_iss_a0", ex_a0, 32'h5);
        chk("lit_iss_b1", ex_b1, 32'h20);
        chk("lit_iss_dst1", ex_dst1, 4'h2);
        chk("lit_iss_free", free_rs, 8'hFF);

        disp(0, 3'd3, 5'h03, 4'h3, 0, 4'h6, 32'h0, 1, 4'h0, 32'h3);
        cycle();
        chk("lit_wait_rdy", rdy, 8'h00);
        cycle();
        chk("lit_wait_rdy2", rdy, 8'h00);
        cv[1] = 1; ct[1] = 4'h6; cd[1] = 32'hABCD;
        cycle();
        chk("lit_wake_rdy", rdy, 8'h10);
        iss(0, 3'd3);
        cycle();
        chk("lit_wake_a0", ex_a0, 32'hABCD);
        chk("lit_wake_b0", ex_b0, 32'h3);

        disp(1, 3'd5, 5'h04, 4'h4, 1, 4'h0, 32'h1, 0, 4'h9, 32'h0);
        cv[0] = 1; ct[0] = 4'h9; cd[0] = 32'h42;
        cycle();
        chk("lit_bypass_rdy", rdy, 8'h04);
        iss(1, 3'd5);
        cycle();
        chk("lit_bypass_b1", ex_b1, 32'h42);
        chk("lit_bypass_exv", {ex_valid0, ex_valid1}, 2'b01);

        // CDB tag collision: CDB0 wins; an already-ready source keeps its value.
        disp(0, 3'd4, 5'h05, 4'h5, 0, 4'h7, 32'h0, 1, 4'h7, 32'h55);
        cycle();
        cv[0] = 1; ct[0] = 4'h7; cd[0] = 32'h111;
        cv[1] = 1; ct[1] = 4'h7; cd[1] = 32'h222;
        cycle();
        iss(0, 3'd4);
        cycle();
        chk("lit_prio_a0", ex_a0, 32'h111);
        chk("lit_prio_b0", ex_b0, 32'h55);

        for (int i = 0; i < 4; i++) begin
            disp(0, 3'(2 * i), 5'(8 + 2 * i), 4'(2 * i), 1, 4'h0, 32'(256 + 2 * i),
                 1, 4'h0, 32'(512 + 2 * i));
            disp(1, 3'(2 * i + 1), 5'(9 + 2 * i), 4'(2 * i + 1), 1, 4'h0, 32'(257 + 2 * i),
                 1, 4'h0, 32'(513 + 2 * i));
            cycle();
        end
        chk("lit_full_free", free_rs, 8'h00);
        chk("lit_full_rdy", rdy, 8'hFF);
        disp(0, 3'd2, 5'h1F, 4'hF, 1, 4'h0, 32'hDEAD, 1, 4'h0, 32'hBEEF);
        cycle();
        chk("lit_full_err", err, 1'b1);
        chk("lit_full_free2", free_rs, 8'h00);
        cycle();
        chk("lit_err_pulse", err, 1'b0);
        iss(0, 3'd2);
        iss(1, 3'd2);
        cycle();
        chk("lit_dup_iss_op0", ex_op0, 5'h0A);
        chk("lit_dup_iss_a0", ex_a0, 32'h102);
        chk("lit_dup_iss_exv", {ex_valid0, ex_valid1}, 2'b10);
        chk("lit_dup_iss_err", err, 1'b1);
        iss(0, 3'd2);
        cycle();
        chk("lit_notrdy_err", err, 1'b1);
        chk("lit_notrdy_exv", ex_valid0, 1'b0);
        disp(0, 3'd2, 5'h11, 4'h1, 1, 4'h0, 32'h1, 1, 4'h0, 32'h2);
        disp(1, 3'd2, 5'h12, 4'h2, 1, 4'h0, 32'h3, 1, 4'h0, 32'h4);
        cycle();
        chk("lit_dup_disp_err", err, 1'b1);
        iss(0, 3'd2);
        cycle();
        chk("lit_dup_disp_op0", ex_op0, 5'h11);

        flush = 1'b1;
        cycle();
        chk("lit_flush_free", free_rs, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            disp(0, 3'(2 * i), 5'h06, 4'h6, 1, 4'h0, 32'h6, 1, 4'h0, 32'h6);
            disp(1, 3'(2 * i + 1), 5'h07, 4'h7, 1, 4'h0, 32'h7, 1, 4'h0, 32'h7);
            cycle();
        end
        chk("lit_four_free", free_rs, 8'h0F);
        flush = 1'b1;
        disp(0, 3'd6, 5'h08, 4'h8, 1, 4'h0, 32'h8, 1, 4'h0, 32'h8);
        iss(0, 3'd0);
        cycle();
        chk("lit_flush2_free", free_rs, 8'hFF);
        chk("lit_flush2_exv", {ex_valid0, ex_valid1}, 2'b00);
        chk("lit_flush2_err", err, 1'b0);
        chk("lit_flush2_rdy", rdy, 8'h00);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
